// File: rtl/riscv_pkg.sv
// Shared RV32I constants and the fetch sequencer state encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and decode-stage handshake bundle.
interface fetch_unit_if
  import riscv_pkg::*;
  ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] pc_plus4;

  logic            is_jal;
  logic            is_jalr;
  logic            branch;
  logic            branch_confirm;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jal_target;
  logic [XLEN-1:0] jalr_target;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst, inst_pc, pc_plus4,
    input  inst_ready, is_jal, is_jalr, branch, branch_confirm,
    input  branch_target, jal_target, jalr_target
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst, inst_pc, pc_plus4,
    output inst_ready, is_jal, is_jalr, branch, branch_confirm,
    output branch_target, jal_target, jalr_target
  );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC priority mux (JAL > JALR > taken branch > sequential) with alignment check.
module next_pc_sel
  import riscv_pkg::*;
  (
    input  logic [XLEN-1:0] inst_pc_i,
    input  logic            is_jal_i,
    input  logic            is_jalr_i,
    input  logic            branch_i,
    input  logic            branch_confirm_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] jal_target_i,
    input  logic [XLEN-1:0] jalr_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            misaligned_o
  );

  always_comb begin
    next_pc_o = inst_pc_i + XLEN'(4);
    if (is_jal_i) begin
      next_pc_o = jal_target_i;
    end else if (is_jalr_i) begin
      next_pc_o = {jalr_target_i[XLEN-1:1], 1'b0};
    end else if (branch_i && branch_confirm_i) begin
      next_pc_o = branch_target_i;
    end
  end

  assign misaligned_o = |next_pc_o[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC sequencer: one outstanding word fetch, held for decode until consumed.
module fetch_unit
  import riscv_pkg::*;
  #(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
  )
  (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus,
    output logic         halted,
    output logic [31:0]  instret
  );

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]     instret_q, instret_d;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  next_pc_sel u_next_pc_sel (
    .inst_pc_i        (inst_pc_q),
    .is_jal_i         (bus.is_jal),
    .is_jalr_i        (bus.is_jalr),
    .branch_i         (bus.branch),
    .branch_confirm_i (bus.branch_confirm),
    .branch_target_i  (bus.branch_target),
    .jal_target_i     (bus.jal_target),
    .jalr_target_i    (bus.jalr_target),
    .next_pc_o        (next_pc),
    .misaligned_o     (misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INSN;
      inst_pc_q <= RESET_PC;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    instret_d = instret_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          inst_d    = bus.imem_rsp_data;
          inst_pc_d = pc_q;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        // A misaligned target is latched into pc but never requested.
        if (bus.inst_ready) begin
          instret_d = instret_q + 32'd1;
          pc_d      = next_pc;
          state_d   = misaligned ? HALT : REQ;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req_valid = (state_q == REQ);
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = (state_q == HOLD);
  assign bus.inst           = (state_q == HOLD) ? inst_q : NOP_INSN;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.pc_plus4       = inst_pc_q + XLEN'(4);
  assign halted             = (state_q == HALT);
  assign instret            = instret_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch and PC sequencer for the single-issue RV32I core. It issues word requests to instruction memory and holds each fetched instruction for the decode/control stage. It consumes that stage's resolved control (is_jal, is_jalr, branch, branch_confirm, plus the computed targets) to select the next PC. It is the producer side of the decode interface and the consumer of its flow-control outputs.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
XLEN, 32, PC/address/instruction width (only 32 supported)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  XLEN  word-aligned fetch address (= pc)
imem_rsp_valid  input  1  response data valid
imem_rsp_data  input  32  fetched instruction word
inst_valid  output  1  instruction presented to decode
inst_ready  input  1  decode/execute consumes instruction this cycle
inst  output  32  held instruction (NOP 32'h0000_0013 when not valid)
inst_pc  output  XLEN  PC of held instruction
pc_plus4  output  XLEN  inst_pc+4, link value for JAL/JALR
is_jal  input  1  resolved control for the held instruction
is_jalr  input  1  resolved control for the held instruction
branch  input  1  resolved control for the held instruction
branch_confirm  input  1  resolved control for the held instruction
branch_target  input  XLEN  inst_pc+imm_b
jal_target  input  XLEN  inst_pc+imm_j
jalr_target  input  XLEN  rs1+imm_i; bit 0 cleared internally
halted  output  1  sticky: misaligned next PC detected
instret  output  32  retired-instruction counter

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=RESET_PC.
  - imem_req_valid=0, inst_valid=0, inst=NOP, inst_pc=RESET_PC.
  - halted=0, instret=0.
- States and transitions:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready go to WAIT; otherwise hold, with addr stable.
  - WAIT: on imem_rsp_valid, capture inst<=imem_rsp_data and inst_pc<=pc, then go to HOLD. imem_rsp_valid is ignored in every state except WAIT.
  - HOLD: inst_valid=1, and inst/inst_pc remain stable until consumed. On inst_ready:
    - instret<=instret+1, wrapping mod 2^32.
    - pc<=next_pc.
    - If next_pc[1:0]!=0, go to HALT; otherwise go to REQ.
  - HALT: halted=1, no requests, inst_valid=0. Exits only on reset.
- next_pc priority, applied only in the HOLD consume cycle:
  1. is_jal -> jal_target.
  2. else is_jalr -> {jalr_target[XLEN-1:1],1'b0}.
  3. else branch&&branch_confirm -> branch_target.
  4. else inst_pc+4, wrapping 32'hFFFF_FFFC -> 0.
- Control inputs are sampled only when HOLD&&inst_ready and are don't-care otherwise.
- Simultaneous assertions: the priority order above decides, e.g. is_jal beats branch. branch_confirm without branch is ignored.
- Latency: minimum 3 cycles per instruction (REQ, WAIT, HOLD), with zero-wait memory and inst_ready tied high.
- A misaligned target sets halted the cycle after consumption. That PC is never presented on imem_addr.
- Reset mid-operation: a request or response in flight is abandoned. A response arriving after reset, in IDLE or REQ, is dropped.
- pc_plus4 is combinational from inst_pc.

Decomposition:
- Package riscv_pkg holds:
  - opcode localparams (R_TYPE, I_TYPE, BRANCH, JAL, JALR, LUI, AUIPC);
  - NOP_INSN=32'h0000_0013;
  - the fetch state encoding (IDLE, REQ, WAIT, HOLD, HALT);
  - XLEN.
- One sub-module, next_pc_sel: combinational priority mux plus misalignment check. It takes the control/targets and inst_pc and outputs next_pc and misaligned.

Test Plan:
- Sequential fetch: RESET_PC=0, zero-wait memory, inst_ready=1.
  - imem_addr goes 0,4,8,0xC, one new address every 3 cycles.
  - instret=4 after the 4th consume.
  - First imem_req_valid appears on the 2nd cycle after reset release.
- Taken branch: held inst_pc=0x10, branch=1, branch_confirm=1, branch_target=0x40 -> next imem_addr=0x40. With branch_confirm=0 -> next imem_addr=0x14.
- Priority and JALR alignment: is_jal=1 with jal_target=0x100, and branch=1, branch_confirm=1 with branch_target=0x200 -> next imem_addr=0x100. Then is_jalr=1, jalr_target=0x305 -> next imem_addr=0x304, and pc_plus4 equals inst_pc+4.
- Backpressure:
  - imem_req_ready low for 5 cycles -> imem_addr stable.
  - inst_ready low for 4 cycles in HOLD -> inst and inst_pc stable, and instret unchanged until the consume.
- Misaligned/halt: branch_target=0x42 -> halted=1 the next cycle, and 0x42 never appears on imem_addr. A subsequent reset clears halted and refetches from RESET_PC.
- Reset mid-WAIT, plus wrap:
  - Assert reset in WAIT, then pulse imem_rsp_valid in IDLE -> inst_valid stays 0 and inst stays NOP.
  - With RESET_PC=32'hFFFF_FFFC, sequential consume -> next imem_addr=0.
